// File: rtl/if_stage_if.sv
// -----------------------------------------------------------------------------
// if_stage_if
//   Bundles every non-clock/reset signal of the instruction-fetch stage.
//
//   Decode side : stall_i, flush_i, redirect_pc_i in; pc_o, inst_o, valid_o out
//   ROM side    : rom_ce_o, rom_addr_o out; rom_data_i in (1-cycle latency)
//   Debug       : dbg_started mirrors the fetch FSM state (1 = fetching)
//
//   Handshake: valid_o/pc_o/inst_o form a registered offer to decode. While
//   stall_i=1 the offer is held unchanged; an offer with valid_o=1 is consumed
//   on every rising edge where stall_i=0. flush_i overrides stall_i and
//   retracts everything not yet consumed.
//
//   master : the fetch stage itself
//   slave  : the environment (decode, ROM, redirect source)
// -----------------------------------------------------------------------------
interface if_stage_if;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] redirect_pc_i;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_data_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        valid_o;
  logic        dbg_started;

  modport master (
    input  stall_i, flush_i, redirect_pc_i, rom_data_i,
    output rom_ce_o, rom_addr_o, pc_o, inst_o, valid_o, dbg_started
  );

  modport slave (
    output stall_i, flush_i, redirect_pc_i, rom_data_i,
    input  rom_ce_o, rom_addr_o, pc_o, inst_o, valid_o, dbg_started
  );
endinterface

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
//   Instruction-fetch stage. Generates the PC, reads a synchronous ROM with a
//   fixed one-cycle latency, and presents {pc_o, inst_o, valid_o} to decode
//   from registers. Decode stalls are absorbed by a 2-entry skid buffer; the
//   issue rule never lets skid occupancy plus the in-flight read exceed the
//   skid depth, so no returned word can ever be dropped.
//
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous, active-low reset
//     bus  - if_stage_if.master (decode handshake, redirect, ROM bus, debug)
//
//   Parameters:
//     RESET_PC   - first fetch address after reset
//     SKID_DEPTH - skid entries; the structure below is built for exactly 2
// -----------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          SKID_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  if_stage_if.master  bus
);

  // Fetch control FSM: idle for one edge after reset, then fetching forever.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

  fetch_state_e state_q, state_d;

  logic [31:0]      pc_q;
  logic [31:0]      issue_pc_q;   // PC of the read currently in flight
  logic             inflight_q;
  logic [1:0]       count_q;
  logic [1:0][31:0] skid_pc_q;    // entry 0 is always the head
  logic [1:0][31:0] skid_inst_q;
  logic [31:0]      out_pc_q;
  logic [31:0]      out_inst_q;
  logic             out_valid_q;

  logic             rom_ce;
  logic [2:0]       occupancy;
  logic             issue_room;
  logic             resp;
  logic             pop;
  logic             push;
  logic             wr_idx;
  logic [1:0]       count_d;
  logic             skid_overflow;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: output logic (ROM issue). Occupancy counts words already buffered
  // plus the one that will land next cycle; issuing only below the skid depth
  // guarantees a stalled decode can hold every word we have asked for.
  assign occupancy  = {1'b0, count_q} + {2'b00, inflight_q};
  assign issue_room = (int'(occupancy) < SKID_DEPTH);

  always_comb begin
    rom_ce = 1'b0;
    if ((state_q == ST_RUN) && !bus.flush_i && issue_room) begin
      rom_ce = 1'b1;
    end
  end

  assign bus.rom_ce_o    = rom_ce;
  assign bus.rom_addr_o  = pc_q;
  assign bus.dbg_started = (state_q == ST_RUN);

  // ---------------------------------------------------------------------------
  // Skid buffer control
  // ---------------------------------------------------------------------------
  assign resp = inflight_q;

  always_comb begin
    pop    = 1'b0;
    push   = 1'b0;
    wr_idx = 1'b0;
    if (!bus.flush_i) begin
      pop  = !bus.stall_i && (count_q != 2'd0);
      // A response is buffered unless it can go straight to the output,
      // which only happens when decode is moving and the skid is empty.
      push = resp && (bus.stall_i || (count_q != 2'd0));
    end
    // Tail slot after this cycle's pop (if any) has shifted the entries down.
    if (pop) begin
      wr_idx = (count_q == 2'd2);
    end else begin
      wr_idx = (count_q == 2'd1);
    end
  end

  always_comb begin
    count_d = count_q;
    if (bus.flush_i) begin
      count_d = 2'd0;
    end else begin
      case ({pop, push})
        2'b10:   count_d = count_q - 2'd1;
        2'b01:   count_d = count_q + 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  assign skid_overflow = push && !pop && (count_q == 2'd2);

  assert property (@(posedge clk) disable iff (!rst) !skid_overflow);

  // ---------------------------------------------------------------------------
  // PC generation and in-flight tracking
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      issue_pc_q <= 32'h0;
      inflight_q <= 1'b0;
    end else begin
      // A flush never issues, so this also retires any in-flight read.
      inflight_q <= rom_ce;
      if (rom_ce) begin
        issue_pc_q <= pc_q;
      end
      if (bus.flush_i) begin
        pc_q <= {bus.redirect_pc_i[31:2], 2'b00};
      end else if (rom_ce) begin
        pc_q <= pc_q + 32'd4;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Skid storage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q     <= 2'd0;
      skid_pc_q   <= '0;
      skid_inst_q <= '0;
    end else begin
      count_q <= count_d;
      if (pop) begin
        skid_pc_q[0]   <= skid_pc_q[1];
        skid_inst_q[0] <= skid_inst_q[1];
      end
      // Written after the shift so a same-cycle push into slot 0 wins.
      if (push) begin
        skid_pc_q[wr_idx]   <= issue_pc_q;
        skid_inst_q[wr_idx] <= bus.rom_data_i;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output register towards decode
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_pc_q    <= 32'h0;
      out_inst_q  <= 32'h0;
      out_valid_q <= 1'b0;
    end else if (bus.flush_i) begin
      out_inst_q  <= 32'h0;
      out_valid_q <= 1'b0;
    end else if (!bus.stall_i) begin
      if (count_q != 2'd0) begin
        out_pc_q    <= skid_pc_q[0];
        out_inst_q  <= skid_inst_q[0];
        out_valid_q <= 1'b1;
      end else if (resp) begin
        out_pc_q    <= issue_pc_q;
        out_inst_q  <= bus.rom_data_i;
        out_valid_q <= 1'b1;
      end else begin
        // Bubble: present a NOP, keep the last PC for debug visibility.
        out_inst_q  <= 32'h0;
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.pc_o    = out_pc_q;
  assign bus.inst_o  = out_inst_q;
  assign bus.valid_o = out_valid_q;

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage
//   Directed scenarios followed by randomized stall/flush/reset traffic.
//   A queue-based model predicts ROM issue and decode outputs every cycle;
//   a few literal expectations pin the model's timing.
// -----------------------------------------------------------------------------
module tb_if_stage;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  if_stage_if bus();
  if_stage_if wbus();

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk (clk),
    .rst (rst),
    .bus (wbus.master)
  );

  // Synchronous ROM: contents are the bitwise inverse of the address.
  logic [31:0] rom_q = '0;
  always @(posedge clk) begin
    if (bus.rom_ce_o) rom_q <= ~bus.rom_addr_o;
  end
  assign bus.rom_data_i = rom_q;

  assign wbus.stall_i       = 1'b0;
  assign wbus.flush_i       = 1'b0;
  assign wbus.redirect_pc_i = 32'h0;
  assign wbus.rom_data_i    = 32'h0;

  logic [31:0] wrap_q[$];
  always @(negedge clk) begin
    if (wbus.rom_ce_o) wrap_q.push_back(wbus.rom_addr_o);
  end

  // ---------------------------------------------------------------------------
  // Scoreboard bookkeeping
  // ---------------------------------------------------------------------------
  int errors = 0;
  int checks = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: words in flight and words waiting for decode are just
  // PC queues; the instruction for a PC is ~PC.
  // ---------------------------------------------------------------------------
  logic [31:0] m_pc, m_out_pc, m_out_inst;
  logic        m_valid, m_started;
  logic [31:0] exp_q[$];   // fetched, not yet handed to decode
  logic [31:0] fly_q[$];   // issued, data arrives next cycle
  logic        m_issue, m_have;
  logic [31:0] m_arr;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pc = 32'h0; m_out_pc = 32'h0; m_out_inst = 32'h0;
      m_valid = 1'b0; m_started = 1'b0;
      exp_q.delete(); fly_q.delete();
    end else begin
      m_issue = m_started && !bus.flush_i && ((exp_q.size() + fly_q.size()) < 2);
      m_have  = (fly_q.size() > 0);
      m_arr   = 32'h0;
      if (m_have) m_arr = fly_q.pop_front();
      if (bus.flush_i) begin
        exp_q.delete();
        m_valid = 1'b0;
        m_out_inst = 32'h0;
        m_pc = bus.redirect_pc_i & 32'hFFFF_FFFC;
      end else begin
        if (!bus.stall_i) begin
          if (exp_q.size() > 0) begin
            m_out_pc = exp_q.pop_front();
            m_out_inst = ~m_out_pc;
            m_valid = 1'b1;
          end else if (m_have) begin
            m_out_pc = m_arr;
            m_out_inst = ~m_arr;
            m_valid = 1'b1;
            m_have = 1'b0;
          end else begin
            m_valid = 1'b0;
            m_out_inst = 32'h0;
          end
        end
        if (m_have) exp_q.push_back(m_arr);
        if (m_issue) begin
          fly_q.push_back(m_pc);
          m_pc = m_pc + 32'd4;
        end
      end
      m_started = 1'b1;
      chk32("skid_bound", 32'(exp_q.size() > 2), 32'd0);
    end
  end

  // Compare process: every falling edge, all DUT outputs against the model.
  logic exp_ce;
  always @(negedge clk) begin
    exp_ce = rst && m_started && !bus.flush_i && ((exp_q.size() + fly_q.size()) < 2);
    chk32("rom_ce",   32'(bus.rom_ce_o), 32'(exp_ce));
    chk32("rom_addr", bus.rom_addr_o,    m_pc);
    chk32("valid",    32'(bus.valid_o),  32'(m_valid));
    chk32("pc",       bus.pc_o,          m_out_pc);
    chk32("inst",     bus.inst_o,        m_out_inst);
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, input logic [31:0] exp_pc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (bus.valid_o) seen = 1'b1;
    end
    if (!seen) begin
      errors++;
      checks++;
      $display("FAIL %s: valid_o never rose within 20 cycles, expected pc %h", name, exp_pc);
    end else begin
      chk32(name, bus.pc_o, exp_pc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    bus.stall_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.redirect_pc_i = 32'h0;
    repeat (3) tick();
    chk32("reset_valid", 32'(bus.valid_o), 32'd0);
    chk32("reset_ce", 32'(bus.rom_ce_o), 32'd0);
    rst = 1'b1;

    // Start-up and steady streaming
    tick();
    chk32("t1_first_ce", 32'(bus.rom_ce_o), 32'd1);
    chk32("t1_first_addr", bus.rom_addr_o, 32'h0);
    chk32("t1_no_valid_yet", 32'(bus.valid_o), 32'd0);
    tick();
    chk32("t1_addr4", bus.rom_addr_o, 32'h4);
    chk32("t1_no_valid_yet2", 32'(bus.valid_o), 32'd0);
    tick();
    chk32("t1_valid", 32'(bus.valid_o), 32'd1);
    chk32("t1_pc0", bus.pc_o, 32'h0);
    chk32("t1_inst0", bus.inst_o, 32'hFFFF_FFFF);
    tick();
    chk32("t1_pc4", bus.pc_o, 32'h4);
    tick();
    chk32("t1_pc8", bus.pc_o, 32'h8);
    chk32("t1_inst8", bus.inst_o, 32'hFFFF_FFF7);

    // Stall for four cycles with pc_o at 0x8
    bus.stall_i = 1'b1;
    tick();
    chk32("t2_hold_pc", bus.pc_o, 32'h8);
    chk32("t2_ce_low", 32'(bus.rom_ce_o), 32'd0);
    repeat (3) tick();
    chk32("t2_still_pc8", bus.pc_o, 32'h8);
    bus.stall_i = 1'b0;
    tick();
    chk32("t2_pcC", bus.pc_o, 32'hC);
    tick();
    chk32("t2_pc10", bus.pc_o, 32'h10);
    tick();
    chk32("t2_pc14", bus.pc_o, 32'h14);

    // Wrapping RESET_PC instance
    chk32("t5_count", 32'(wrap_q.size() >= 4), 32'd1);
    if (wrap_q.size() >= 4) begin
      chk32("t5_a0", wrap_q[0], 32'hFFFF_FFF8);
      chk32("t5_a1", wrap_q[1], 32'hFFFF_FFFC);
      chk32("t5_a2", wrap_q[2], 32'h0000_0000);
      chk32("t5_a3", wrap_q[3], 32'h0000_0004);
    end

    // Flush while stalled with a full skid
    bus.stall_i = 1'b1;
    repeat (3) tick();
    bus.flush_i = 1'b1;
    bus.redirect_pc_i = 32'h100;
    tick();
    chk32("t3_valid_cleared", 32'(bus.valid_o), 32'd0);
    bus.flush_i = 1'b0;
    #1;
    chk32("t3_issue_ce", 32'(bus.rom_ce_o), 32'd1);
    chk32("t3_issue_addr", bus.rom_addr_o, 32'h100);
    repeat (2) tick();
    bus.stall_i = 1'b0;
    wait_valid("t3_first_pc", 32'h100);

    // Flush with an unaligned redirect while a read is in flight
    repeat (3) tick();
    bus.flush_i = 1'b1;
    bus.redirect_pc_i = 32'h0000_0103;
    tick();
    bus.flush_i = 1'b0;
    #1;
    chk32("t6_issue_addr", bus.rom_addr_o, 32'h100);
    wait_valid("t6_first_pc", 32'h100);
    chk32("t6_inst", bus.inst_o, 32'hFFFF_FEFF);

    // Asynchronous reset between edges
    repeat (3) tick();
    #1;
    rst = 1'b0;
    #1;
    chk32("t4_pc", bus.pc_o, 32'h0);
    chk32("t4_inst", bus.inst_o, 32'h0);
    chk32("t4_valid", 32'(bus.valid_o), 32'd0);
    chk32("t4_ce", 32'(bus.rom_ce_o), 32'd0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    chk32("t4_restart_addr", bus.rom_addr_o, 32'h0);
    chk32("t4_restart_ce", 32'(bus.rom_ce_o), 32'd1);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      bus.stall_i = ($urandom_range(0, 99) < 30);
      bus.flush_i = ($urandom_range(0, 99) < 6);
      case ($urandom_range(0, 2))
        0:       bus.redirect_pc_i = $urandom & 32'h0000_0FFF;
        1:       bus.redirect_pc_i = $urandom;
        default: bus.redirect_pc_i = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      endcase
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b0;
        #2;
        rst = 1'b1;
      end
      tick();
    end

    bus.stall_i = 1'b0;
    bus.flush_i = 1'b0;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
